// File: rtl/accel_axis_proc_pkg.sv
// Shared constants, FSM state type and the display-limit helper for the
// accelerometer post-processor.
package accel_pkg;

  localparam int NUM_CH_DEF    = 3;
  localparam int IN_W_DEF      = 16;
  localparam int AVG_LOG2_DEF  = 2;
  localparam int SCALE_DIV_DEF = 10;
  localparam int OUT_W_DEF     = 8;
  localparam int DIGITS_DEF    = 2;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    PRESENT
  } state_t;

  // Largest value that fits both the binary magnitude field and the BCD digits.
  function automatic int calc_maxv(input int out_w, input int digits);
    longint p2;
    longint p10;
    p2  = (longint'(1) << out_w) - 1;
    p10 = 1;
    for (int i = 0; i < digits; i++) p10 = p10 * 10;
    p10 = p10 - 1;
    return int'((p2 < p10) ? p2 : p10);
  endfunction

endpackage

// File: rtl/accel_axis_proc_seq_divider.sv
// Unsigned restoring divider: one load cycle, then one quotient bit per cycle.
// done pulses for one cycle once quotient/remainder are final.
module seq_divider #(
  parameter int IN_W = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [IN_W-1:0] dividend,
  input  logic [IN_W-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [IN_W-1:0] quotient,
  output logic [IN_W-1:0] remainder
);

  localparam int CNT_W = $clog2(IN_W + 1);

  logic [IN_W-1:0]  quo_q, quo_d;
  logic [IN_W-1:0]  rem_q, rem_d;
  logic [IN_W-1:0]  dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IN_W:0]    trial;
  logic [IN_W:0]    diff;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    trial  = {rem_q, quo_q[IN_W-1]};
    diff   = trial - {1'b0, dvs_q};
    if (start) begin
      quo_d  = dividend;
      rem_d  = '0;
      dvs_d  = divisor;
      cnt_d  = CNT_W'(IN_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      // A borrow out of the trial subtraction means restore (keep the shifted value).
      quo_d = {quo_q[IN_W-2:0], ~diff[IN_W]};
      rem_d = diff[IN_W] ? trial[IN_W-1:0] : diff[IN_W-1:0];
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/accel_axis_proc.sv
// Multi-axis accelerometer post-processor: block average, sign/magnitude,
// saturating scale and BCD conversion on one shared sequential divider.
module accel_axis_proc
  import accel_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int IN_W      = IN_W_DEF,
  parameter int AVG_LOG2  = AVG_LOG2_DEF,
  parameter int SCALE_DIV = SCALE_DIV_DEF,
  parameter int OUT_W     = OUT_W_DEF,
  parameter int DIGITS    = DIGITS_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sample_valid,
  input  logic [NUM_CH*IN_W-1:0]     sample_data,
  input  logic                       hold,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [NUM_CH*OUT_W-1:0]    out_mag,
  output logic [NUM_CH-1:0]          out_sign,
  output logic [NUM_CH-1:0]          out_sat,
  output logic [NUM_CH*DIGITS*4-1:0] out_bcd,
  output logic                       overrun
);

  localparam int ACC_W = IN_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int K_W   = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(DIGITS);
  localparam logic [IN_W-1:0]  MAXV_W   = IN_W'(calc_maxv(OUT_W, DIGITS));

  state_t state_q, state_d;

  logic signed [ACC_W-1:0] acc_q [NUM_CH];
  logic signed [ACC_W-1:0] acc_d [NUM_CH];
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IN_W-1:0]         absv_q [NUM_CH];
  logic [IN_W-1:0]         absv_d [NUM_CH];
  logic [NUM_CH-1:0]       sign_w_q, sign_w_d;
  logic [OUT_W-1:0]        res_mag_q [NUM_CH];
  logic [OUT_W-1:0]        res_mag_d [NUM_CH];
  logic [NUM_CH-1:0]       res_sat_q, res_sat_d;
  logic [3:0]              res_bcd_q [NUM_CH][DIGITS];
  logic [3:0]              res_bcd_d [NUM_CH][DIGITS];
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [K_W-1:0]          k_q, k_d;
  logic                    go_q, go_d;
  logic                    commit_q, commit_d;

  logic [NUM_CH*OUT_W-1:0]    out_mag_q, out_mag_d;
  logic [NUM_CH-1:0]          out_sign_q, out_sign_d;
  logic [NUM_CH-1:0]          out_sat_q, out_sat_d;
  logic [NUM_CH*DIGITS*4-1:0] out_bcd_q, out_bcd_d;
  logic                       overrun_q, overrun_d;

  logic                    accept, blk_done, free, take;
  logic signed [IN_W-1:0]  samp [NUM_CH];
  logic signed [ACC_W-1:0] sum [NUM_CH];
  logic [IN_W-1:0]         avg [NUM_CH];
  logic [IN_W-1:0]         blk_abs [NUM_CH];
  logic [NUM_CH-1:0]       blk_neg;

  logic            last_op, sat_now, div_start, div_busy, div_done;
  logic [K_W-1:0]  nxt_k, iss_k;
  logic [CH_W-1:0] nxt_ch, iss_ch;
  logic [IN_W-1:0] clamped, div_dividend, div_divisor, div_quo, div_rem;

  // Block accumulation and the sign/magnitude of the completing block.
  always_comb begin
    accept   = sample_valid && !hold;
    blk_done = accept && (cnt_q == BLK_LAST);
    free     = (state_q == IDLE) || ((state_q == PRESENT) && out_ready);
    take     = blk_done && free;
    for (int c = 0; c < NUM_CH; c++) begin
      samp[c]    = sample_data[c*IN_W +: IN_W];
      sum[c]     = acc_q[c] + ACC_W'(samp[c]);
      avg[c]     = IN_W'(sum[c] >>> AVG_LOG2);
      blk_neg[c] = avg[c][IN_W-1];
      blk_abs[c] = blk_neg[c] ? (~avg[c] + 1'b1) : avg[c];
    end
  end

  // Operation sequencing: per channel one scale division, then DIGITS ÷10 steps.
  always_comb begin
    last_op   = (ch_q == CH_LAST) && (k_q == K_LAST);
    nxt_k     = (k_q == K_LAST) ? '0 : k_q + 1'b1;
    nxt_ch    = (k_q != K_LAST) ? ch_q : ((ch_q == CH_LAST) ? '0 : ch_q + 1'b1);
    iss_k     = go_q ? k_q : nxt_k;
    iss_ch    = go_q ? ch_q : nxt_ch;
    sat_now   = div_quo > MAXV_W;
    clamped   = sat_now ? MAXV_W : div_quo;
    div_start = (state_q == CALC) && !div_busy && (go_q || (div_done && !last_op));
    if (iss_k == '0) begin
      div_dividend = absv_q[iss_ch];
      div_divisor  = IN_W'(SCALE_DIV);
    end else begin
      div_dividend = (iss_k == K_W'(1)) ? clamped : div_quo;
      div_divisor  = IN_W'(10);
    end
  end

  seq_divider #(.IN_W(IN_W)) u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (div_start),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    absv_d     = absv_q;
    sign_w_d   = sign_w_q;
    res_mag_d  = res_mag_q;
    res_sat_d  = res_sat_q;
    res_bcd_d  = res_bcd_q;
    ch_d       = ch_q;
    k_d        = k_q;
    go_d       = 1'b0;
    commit_d   = 1'b0;
    out_mag_d  = out_mag_q;
    out_sign_d = out_sign_q;
    out_sat_d  = out_sat_q;
    out_bcd_d  = out_bcd_q;
    overrun_d  = blk_done && !free;
    if (accept) begin
      cnt_d = blk_done ? '0 : cnt_q + 1'b1;
      for (int c = 0; c < NUM_CH; c++) acc_d[c] = blk_done ? '0 : sum[c];
    end
    if (take) begin
      absv_d   = blk_abs;
      sign_w_d = blk_neg;
      ch_d     = '0;
      k_d      = '0;
      go_d     = 1'b1;
    end
    if ((state_q == CALC) && div_done) begin
      if (k_q == '0) begin
        res_mag_d[ch_q] = OUT_W'(clamped);
        res_sat_d[ch_q] = sat_now;
      end
      for (int d = 0; d < DIGITS; d++)
        if (k_q == K_W'(d + 1)) res_bcd_d[ch_q][d] = 4'(div_rem);
      ch_d     = nxt_ch;
      k_d      = nxt_k;
      commit_d = last_op;
    end
    if ((state_q == CALC) && commit_q) begin
      out_sign_d = sign_w_q;
      out_sat_d  = res_sat_q;
      for (int c = 0; c < NUM_CH; c++) begin
        out_mag_d[c*OUT_W +: OUT_W] = res_mag_q[c];
        for (int d = 0; d < DIGITS; d++) out_bcd_d[(c*DIGITS+d)*4 +: 4] = res_bcd_q[c][d];
      end
    end
  end

  // NOTE: the work arrays are a handful of flops, not a RAM, so they reset with everything else.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c]     <= '0;
        absv_q[c]    <= '0;
        res_mag_q[c] <= '0;
        for (int d = 0; d < DIGITS; d++) res_bcd_q[c][d] <= '0;
      end
      cnt_q      <= '0;
      sign_w_q   <= '0;
      res_sat_q  <= '0;
      ch_q       <= '0;
      k_q        <= '0;
      go_q       <= 1'b0;
      commit_q   <= 1'b0;
      out_mag_q  <= '0;
      out_sign_q <= '0;
      out_sat_q  <= '0;
      out_bcd_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      absv_q     <= absv_d;
      res_mag_q  <= res_mag_d;
      res_bcd_q  <= res_bcd_d;
      cnt_q      <= cnt_d;
      sign_w_q   <= sign_w_d;
      res_sat_q  <= res_sat_d;
      ch_q       <= ch_d;
      k_q        <= k_d;
      go_q       <= go_d;
      commit_q   <= commit_d;
      out_mag_q  <= out_mag_d;
      out_sign_q <= out_sign_d;
      out_sat_q  <= out_sat_d;
      out_bcd_q  <= out_bcd_d;
      overrun_q  <= overrun_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = CALC;
      CALC:    if (commit_q) state_d = PRESENT;
      PRESENT: if (take) state_d = CALC;
               else if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == PRESENT);
    out_mag   = out_mag_q;
    out_sign  = out_sign_q;
    out_sat   = out_sat_q;
    out_bcd   = out_bcd_q;
    overrun   = overrun_q;
  end

endmodule

// File: tb/tb_accel_axis_proc.sv
// Directed bench for accel_axis_proc at default parameters: averaging, sign,
// saturation, BCD, latency, overrun, hold and mid-calculation reset.
module tb_accel_axis_proc;

  localparam int LAT = 155;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_valid;
  logic [47:0] sample_data;
  logic        hold;
  logic        out_ready;
  logic        out_valid;
  logic [23:0] out_mag;
  logic [2:0]  out_sign;
  logic [2:0]  out_sat;
  logic [23:0] out_bcd;
  logic        overrun;

  int n_checks = 0;
  int n_pass   = 0;
  int ovr_cnt  = 0;

  accel_axis_proc dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .hold         (hold),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_mag      (out_mag),
    .out_sign     (out_sign),
    .out_sat      (out_sat),
    .out_bcd      (out_bcd),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (overrun === 1'b1) ovr_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One accepted (or held) strobe; returns 1 time unit after the sampling edge.
  task automatic strobe(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                        input logic hld);
    @(posedge clk); #1;
    sample_valid = 1'b1;
    sample_data  = {z, y, x};
    hold         = hld;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    hold         = 1'b0;
  endtask

  task automatic block4(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    for (int i = 0; i < 4; i++) strobe(x, y, z, 1'b0);
  endtask

  task automatic wait_lat(input string tag);
    int cycles = 0;
    while (out_valid !== 1'b1 && cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
    end
    check({tag, ".latency"}, 64'(cycles), 64'(LAT));
  endtask

  task automatic expect_res(input string tag, input logic [23:0] mag, input logic [2:0] sgn,
                            input logic [2:0] sat, input logic [23:0] bcd);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".mag"},   64'(out_mag),   64'(mag));
    check({tag, ".sign"},  64'(out_sign),  64'(sgn));
    check({tag, ".sat"},   64'(out_sat),   64'(sat));
    check({tag, ".bcd"},   64'(out_bcd),   64'(bcd));
  endtask

  task automatic accept_res(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".drop_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n      = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
    hold         = 1'b0;
    out_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.valid",   64'(out_valid), 64'd0);
    check("rst.mag",     64'(out_mag),   64'd0);
    check("rst.bcd",     64'(out_bcd),   64'd0);
    check("rst.sign",    64'(out_sign),  64'd0);
    check("rst.sat",     64'(out_sat),   64'd0);
    check("rst.overrun", 64'(overrun),   64'd0);
    #2 reset_n = 1'b1;

    // Basic three-axis block: 100/-50/0 -> 10/5/0.
    block4(16'd100, -16'sd50, 16'd0);
    wait_lat("t1");
    expect_res("t1", {8'd0, 8'd5, 8'd10}, 3'b010, 3'b000, 24'h00_05_10);
    accept_res("t1");

    // Saturation at 99.
    block4(16'd1000, 16'd0, 16'd0);
    wait_lat("t2");
    expect_res("t2", {8'd0, 8'd0, 8'd99}, 3'b000, 3'b001, 24'h00_00_99);
    accept_res("t2");

    // Most negative input: magnitude 32768, saturates.
    block4(16'h8000, 16'd0, 16'd0);
    wait_lat("t3");
    expect_res("t3", {8'd0, 8'd0, 8'd99}, 3'b001, 3'b001, 24'h00_00_99);
    accept_res("t3");

    // Floor averaging: sum -5 -> -2.
    strobe(-16'sd1, 16'd0, 16'd0, 1'b0);
    strobe(-16'sd1, 16'd0, 16'd0, 1'b0);
    strobe(-16'sd1, 16'd0, 16'd0, 1'b0);
    strobe(-16'sd2, 16'd0, 16'd0, 1'b0);
    wait_lat("t4");
    expect_res("t4", 24'd0, 3'b001, 3'b000, 24'h00_00_00);
    accept_res("t4");

    // Averaging 39,41,40,40 -> 40 -> 4; left pending for the overrun test.
    strobe(16'd39, 16'd0, 16'd0, 1'b0);
    strobe(16'd41, 16'd0, 16'd0, 1'b0);
    strobe(16'd40, 16'd0, 16'd0, 1'b0);
    strobe(16'd40, 16'd0, 16'd0, 1'b0);
    wait_lat("t5");
    expect_res("t5", {8'd0, 8'd0, 8'd4}, 3'b000, 3'b000, 24'h00_00_04);

    // A completed block while the result is unconsumed is dropped.
    block4(16'd100, 16'd0, 16'd0);
    check("ovr.pulse", 64'(overrun), 64'd1);
    @(posedge clk); #1;
    check("ovr.clear", 64'(overrun), 64'd0);
    check("ovr.count", 64'(ovr_cnt), 64'd1);
    expect_res("ovr.hold_out", {8'd0, 8'd0, 8'd4}, 3'b000, 3'b000, 24'h00_00_04);
    accept_res("ovr");

    // Held strobes are ignored: only the 20s count.
    strobe(16'd20,  16'd0,   16'd0,   1'b0);
    strobe(16'd500, 16'd500, 16'd500, 1'b1);
    strobe(16'd20,  16'd0,   16'd0,   1'b0);
    strobe(16'd500, 16'd500, 16'd500, 1'b1);
    strobe(16'd20,  16'd0,   16'd0,   1'b0);
    strobe(16'd20,  16'd0,   16'd0,   1'b0);
    wait_lat("hold");
    expect_res("hold", {8'd0, 8'd0, 8'd2}, 3'b000, 3'b000, 24'h00_00_02);
    check("hold.no_overrun", 64'(ovr_cnt), 64'd1);
    accept_res("hold");

    // Reset mid-calculation with a partial next block in the accumulators.
    block4(16'd100, -16'sd50, 16'd0);
    strobe(16'd1000, 16'd1000, 16'd1000, 1'b0);
    strobe(16'd1000, 16'd1000, 16'd1000, 1'b0);
    repeat (40) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst.valid", 64'(out_valid), 64'd0);
    check("mid_rst.mag",   64'(out_mag),   64'd0);
    check("mid_rst.bcd",   64'(out_bcd),   64'd0);
    @(posedge clk); #2 reset_n = 1'b1;

    // 250/-999/77 -> 25/99 (exactly at the limit, not clamped)/7.
    block4(16'd250, -16'sd999, 16'd77);
    wait_lat("post_rst");
    expect_res("post_rst", {8'd7, 8'd99, 8'd25}, 3'b010, 3'b000, 24'h07_99_25);
    accept_res("post_rst");
    check("final.overrun_count", 64'(ovr_cnt), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
